// File: rtl/conv_pkg.sv
// Shared types and helpers for the 3x3 convolution frame controller.
//   state_e   : frame sequencer states
//   idx(r,c)  : element index inside a packed 3x3 patch/kernel (r*3+c)
package conv_pkg;

  localparam int unsigned PIX_W_DEF = 8;
  localparam int unsigned OUT_W_DEF = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } state_e;

  function automatic int unsigned idx(input int unsigned r, input int unsigned c);
    return r * 3 + c;
  endfunction

endpackage

// File: rtl/conv3x3_window_buf.sv
// Two line buffers plus a 3x3 sliding window over a raster pixel stream.
// Ports:
//   clk, rst_n    : clock, async active-low reset
//   clear         : restart position counters for a new frame
//   shift_en      : one pixel accepted this cycle
//   pix_data      : accepted pixel
//   patch         : current window, element (r,c) at idx(r,c)*PIX_W, r=0 oldest row
//   window_valid  : window holds a complete in-row 3x3 patch (cycle after the shift)
//   last_pix_c    : current position is the last pixel of the frame
module conv3x3_window_buf
  import conv_pkg::*;
#(
  parameter int unsigned IMG_W = 16,
  parameter int unsigned IMG_H = 16,
  parameter int unsigned PIX_W = PIX_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 shift_en,
  input  logic [PIX_W-1:0]     pix_data,
  output logic [9*PIX_W-1:0]   patch,
  output logic                 window_valid,
  output logic                 last_pix_c
);

  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);

  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;
  logic             col_last_c;
  logic             row_last_c;

  logic [PIX_W-1:0] lb0_q [IMG_W];
  logic [PIX_W-1:0] lb1_q [IMG_W];
  logic [PIX_W-1:0] win_q [3][3];

  assign col_last_c = (col_q == COL_W'(IMG_W - 1));
  assign row_last_c = (row_q == ROW_W'(IMG_H - 1));
  assign last_pix_c = col_last_c && row_last_c;

  // Raster position of the next pixel to arrive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else if (clear) begin
      col_q <= '0;
      row_q <= '0;
    end else if (shift_en) begin
      if (col_last_c) begin
        col_q <= '0;
        row_q <= row_last_c ? '0 : row_q + ROW_W'(1);
      end else begin
        col_q <= col_q + COL_W'(1);
      end
    end
  end

  // Patch ready only once three rows and three columns of the current row are in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      window_valid <= 1'b0;
    end else begin
      window_valid <= shift_en && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
    end
  end

  // Line buffers and window shift; new right column is {lb1, lb0, pixel} top to bottom
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < IMG_W; i++) begin
        lb0_q[i] <= '0;
        lb1_q[i] <= '0;
      end
      for (int unsigned r = 0; r < 3; r++) begin
        for (int unsigned c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else if (shift_en) begin
      lb1_q[col_q] <= lb0_q[col_q];
      lb0_q[col_q] <= pix_data;
      for (int unsigned r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= win_q[r][2];
      end
      win_q[0][2] <= lb1_q[col_q];
      win_q[1][2] <= lb0_q[col_q];
      win_q[2][2] <= pix_data;
    end
  end

  // Pack window into the conv-unit patch layout
  always_comb begin
    patch = '0;
    for (int unsigned r = 0; r < 3; r++) begin
      for (int unsigned c = 0; c < 3; c++) begin
        patch[idx(r, c)*PIX_W +: PIX_W] = win_q[r][c];
      end
    end
  end

endmodule

// File: rtl/conv3x3_frame_ctrl.sv
// Frame sequencer for the 3x3 convolution datapath (valid conv, stride 1).
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   start               : begin a frame (IDLE only)
//   kernel_in, bias_in  : coefficients, latched on start
//   pix_valid/pix_data/pix_ready : raster input stream
//   patch_out/kernel_out/bias_out/patch_valid : to Convolution3x3
//   conv_result         : Convolution3x3 output, valid CONV_LAT cycles after patch_valid
//   res_valid/res_data  : results in raster order (no backpressure)
//   busy, done          : not IDLE / one-cycle end-of-frame pulse
module conv3x3_frame_ctrl
  import conv_pkg::*;
#(
  parameter int unsigned IMG_W    = 16,
  parameter int unsigned IMG_H    = 16,
  parameter int unsigned PIX_W    = PIX_W_DEF,
  parameter int unsigned OUT_W    = OUT_W_DEF,
  parameter int unsigned CONV_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [9*PIX_W-1:0]   kernel_in,
  input  logic [PIX_W-1:0]     bias_in,
  input  logic                 pix_valid,
  input  logic [PIX_W-1:0]     pix_data,
  output logic                 pix_ready,
  output logic [9*PIX_W-1:0]   patch_out,
  output logic [9*PIX_W-1:0]   kernel_out,
  output logic [PIX_W-1:0]     bias_out,
  output logic                 patch_valid,
  input  logic [OUT_W-1:0]     conv_result,
  output logic                 res_valid,
  output logic [OUT_W-1:0]     res_data,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned N_RES = (IMG_W - 2) * (IMG_H - 2);
  localparam int unsigned RC_W  = $clog2(N_RES + 1);

  state_e              state_q;
  state_e              state_d;
  logic                start_c;
  logic                xfer_c;
  logic                last_pix_c;
  logic                res_last_c;
  logic [CONV_LAT-1:0] vld_sr_q;
  logic [RC_W-1:0]     rc_q;

  assign start_c    = start && (state_q == IDLE);
  assign xfer_c     = pix_valid && pix_ready;
  assign res_valid  = vld_sr_q[CONV_LAT-1];
  assign res_data   = res_valid ? conv_result : '0;
  assign res_last_c = res_valid && (rc_q == RC_W'(N_RES - 1));

  conv3x3_window_buf #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .PIX_W (PIX_W)
  ) u_window_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (start_c),
    .shift_en     (xfer_c),
    .pix_data     (pix_data),
    .patch        (patch_out),
    .window_valid (patch_valid),
    .last_pix_c   (last_pix_c)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; the final result may land in STREAM only with the last pixel
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (start_c) state_d = STREAM;
      STREAM: if (xfer_c && last_pix_c) state_d = res_last_c ? DONE : DRAIN;
      DRAIN:  if (res_last_c) state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs registered from the next state so they align with state_q
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      pix_ready <= (state_d == STREAM);
      busy      <= (state_d != IDLE);
      done      <= (state_d == DONE);
    end
  end

  // Coefficients held for the whole frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kernel_out <= '0;
      bias_out   <= '0;
    end else if (start_c) begin
      kernel_out <= kernel_in;
      bias_out   <= bias_in;
    end
  end

  // Conv-unit latency tracker
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr_q <= '0;
    end else begin
      vld_sr_q[0] <= patch_valid;
      for (int unsigned i = 1; i < CONV_LAT; i++) begin
        vld_sr_q[i] <= vld_sr_q[i-1];
      end
    end
  end

  // Result counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rc_q <= '0;
    end else if (start_c) begin
      rc_q <= '0;
    end else if (res_valid) begin
      rc_q <= rc_q + RC_W'(1);
    end
  end

endmodule

// File: tb/tb_conv3x3_frame_ctrl.sv
// Directed bench for conv3x3_frame_ctrl: 4x4/LAT1 instance and 5x3/LAT3 instance,
// each fed by a behavioural Convolution3x3 model.
module tb_conv3x3_frame_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- instance A: 4x4, CONV_LAT=1 ----------------
  logic        start_a, pv_a, pr_a, patchv_a, resv_a, busy_a, done_a;
  logic [71:0] kernel_a, patch_a, kout_a;
  logic [7:0]  bias_a, pd_a, bout_a;
  logic [9:0]  conv_a, resd_a;

  conv3x3_frame_ctrl #(.IMG_W(4), .IMG_H(4), .PIX_W(8), .OUT_W(10), .CONV_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .kernel_in(kernel_a), .bias_in(bias_a),
    .pix_valid(pv_a), .pix_data(pd_a), .pix_ready(pr_a), .patch_out(patch_a),
    .kernel_out(kout_a), .bias_out(bout_a), .patch_valid(patchv_a), .conv_result(conv_a),
    .res_valid(resv_a), .res_data(resd_a), .busy(busy_a), .done(done_a)
  );

  // ---------------- instance B: 5x3, CONV_LAT=3 ----------------
  logic        start_b, pv_b, pr_b, patchv_b, resv_b, busy_b, done_b;
  logic [71:0] kernel_b, patch_b, kout_b;
  logic [7:0]  bias_b, pd_b, bout_b;
  logic [9:0]  conv_b, p0_b, p1_b, resd_b;

  conv3x3_frame_ctrl #(.IMG_W(5), .IMG_H(3), .PIX_W(8), .OUT_W(10), .CONV_LAT(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .kernel_in(kernel_b), .bias_in(bias_b),
    .pix_valid(pv_b), .pix_data(pd_b), .pix_ready(pr_b), .patch_out(patch_b),
    .kernel_out(kout_b), .bias_out(bout_b), .patch_valid(patchv_b), .conv_result(conv_b),
    .res_valid(resv_b), .res_data(resd_b), .busy(busy_b), .done(done_b)
  );

  function automatic logic [9:0] conv_sum(input logic [71:0] p, input logic [71:0] k,
                                          input logic [7:0] b);
    int s;
    s = int'(b);
    for (int i = 0; i < 9; i++) s += int'(p[i*8 +: 8]) * int'(k[i*8 +: 8]);
    return 10'(s);
  endfunction

  // Convolution3x3 models: registered product-sum, LAT-1 extra stages
  always @(posedge clk) conv_a <= conv_sum(patch_a, kout_a, bout_a);
  always @(posedge clk) begin
    p0_b   <= conv_sum(patch_b, kout_b, bout_b);
    p1_b   <= p0_b;
    conv_b <= p1_b;
  end

  // Monitors
  logic [9:0]  rq_a[$];
  logic [71:0] first_patch_a;
  bit          first_seen_a, xfer_prev_a;
  int          done_cnt_a = 0, done_cyc_a = 0, last_res_cyc_a = 0, pv_bad_a = 0;

  always @(negedge clk) begin
    if (resv_a) begin rq_a.push_back(resd_a); last_res_cyc_a = cyc; end
    if (done_a) begin done_cnt_a++; done_cyc_a = cyc; end
    if (patchv_a && !xfer_prev_a) pv_bad_a++;
    if (patchv_a && !first_seen_a) begin first_patch_a = patch_a; first_seen_a = 1'b1; end
    xfer_prev_a = pv_a && pr_a;
  end

  logic [9:0] rq_b[$];
  int         pcyc_b[$], rcyc_b[$];
  int         done_cnt_b = 0, done_cyc_b = 0;

  always @(negedge clk) begin
    if (patchv_b) pcyc_b.push_back(cyc);
    if (resv_b) begin rq_b.push_back(resd_b); rcyc_b.push_back(cyc); end
    if (done_b) begin done_cnt_b++; done_cyc_b = cyc; end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_frame_a(input logic [71:0] k, input logic [7:0] b);
    kernel_a = k; bias_a = b;
    rq_a.delete(); first_seen_a = 1'b0; pv_bad_a = 0;
    start_a = 1'b1; tick(1); start_a = 1'b0;
  endtask

  task automatic send_a(input logic [7:0] d, input bit stall);
    int n;
    if (stall) begin pv_a = 1'b0; tick(1); end
    pv_a = 1'b1; pd_a = d; n = 0;
    while (!pr_a && n < 50) begin tick(1); n++; end
    if (n >= 50) chk("a_ready_timeout", 0, 1);
    tick(1); pv_a = 1'b0;
  endtask

  task automatic wait_done_a(input string tag);
    int d0, n;
    d0 = done_cnt_a; n = 0;
    while (done_cnt_a == d0 && n < 100) begin @(negedge clk); #1; n++; end
    chk({tag, "_done_seen"}, done_cnt_a - d0, 1);
    @(posedge clk); #1;
  endtask

  task automatic check_frame_a(input string tag, input int e0, input int e1,
                               input int e2, input int e3);
    int         e[4];
    logic [9:0] got;
    e = '{e0, e1, e2, e3};
    chk({tag, "_count"}, rq_a.size(), 4);
    for (int i = 0; i < 4; i++) begin
      got = (i < rq_a.size()) ? rq_a[i] : 10'h3ff;
      chk($sformatf("%s_res%0d", tag, i), got, e[i]);
    end
    chk({tag, "_done_after_last"}, done_cyc_a - last_res_cyc_a, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [71:0] k1, k2;
    logic [9:0]  gb;
    int          d0, n, eb[3];
    k1 = {9{8'd1}};
    k2 = {9{8'd2}};
    rst_n = 1'b0;
    start_a = 0; pv_a = 0; pd_a = 0; kernel_a = 0; bias_a = 0;
    start_b = 0; pv_b = 0; pd_b = 0; kernel_b = 0; bias_b = 0;

    #12;
    chk("rst_ctrl", {pr_a, patchv_a, resv_a, busy_a, done_a, resd_a, bout_a}, 0);
    chk("rst_patch_kernel", {patch_a, kout_a}, 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Frame 1: kernel all 1, bias 0, back-to-back
    start_frame_a(k1, 8'd0);
    chk("f1_busy", busy_a, 1);
    chk("f1_kernel_latched", kout_a, k1);
    for (int p = 1; p <= 16; p++) send_a(8'(p), 1'b0);
    chk("f1_ready_low_after_last", pr_a, 0);
    wait_done_a("f1");
    check_frame_a("f1", 54, 63, 90, 99);
    chk("f1_first_patch", first_patch_a, 72'h0b0a09070605030201);
    chk("f1_busy_end", busy_a, 0);
    chk("f1_done_count", done_cnt_a, 1);

    // Frame 2: kernel all 2, bias 1; inputs change after start
    start_frame_a(k2, 8'd1);
    kernel_a = '0; bias_a = '0;
    for (int p = 1; p <= 16; p++) send_a(8'(p), 1'b0);
    wait_done_a("f2");
    check_frame_a("f2", 109, 127, 181, 199);
    chk("f2_bias_latched", bout_a, 1);

    // Frame 3: stall every other cycle
    start_frame_a(k1, 8'd0);
    for (int p = 1; p <= 16; p++) send_a(8'(p), 1'b1);
    chk("f3_ready_low_after_last", pr_a, 0);
    wait_done_a("f3");
    check_frame_a("f3", 54, 63, 90, 99);
    chk("f3_no_patch_on_stall", pv_bad_a, 0);

    // Frame 4: start pulses while busy are ignored
    d0 = done_cnt_a;
    start_frame_a(k1, 8'd0);
    for (int p = 1; p <= 5; p++) send_a(8'(p), 1'b0);
    start_a = 1'b1; kernel_a = k2;
    send_a(8'd6, 1'b0);
    start_a = 1'b0;
    for (int p = 7; p <= 16; p++) send_a(8'(p), 1'b0);
    start_a = 1'b1; tick(1); start_a = 1'b0;
    wait_done_a("f4");
    tick(20);
    chk("f4_single_done", done_cnt_a - d0, 1);
    chk("f4_idle", busy_a, 0);
    check_frame_a("f4", 54, 63, 90, 99);

    // Frame 5: fresh start from IDLE after done
    start_frame_a(k1, 8'd0);
    for (int p = 1; p <= 16; p++) send_a(8'(p), 1'b0);
    wait_done_a("f5");
    check_frame_a("f5", 54, 63, 90, 99);

    // Async reset mid-frame after pixel 10
    d0 = done_cnt_a;
    start_frame_a(k2, 8'd1);
    for (int p = 1; p <= 10; p++) send_a(8'(p), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ctrl", {pr_a, patchv_a, resv_a, busy_a, done_a, resd_a, bout_a}, 0);
    chk("mid_rst_patch_kernel", {patch_a, kout_a}, 0);
    #3 rst_n = 1'b1;
    tick(3);
    chk("mid_rst_no_resume", {busy_a, pr_a}, 0);
    chk("mid_rst_no_done", done_cnt_a - d0, 0);
    start_frame_a(k1, 8'd0);
    for (int p = 1; p <= 16; p++) send_a(8'(p), 1'b0);
    wait_done_a("f6");
    check_frame_a("f6", 54, 63, 90, 99);

    // Instance B: 5x3 frame, CONV_LAT=3
    kernel_b = k1; bias_b = 8'd0;
    start_b = 1'b1; tick(1); start_b = 1'b0;
    for (int p = 1; p <= 15; p++) begin
      pv_b = 1'b1; pd_b = 8'(p); n = 0;
      while (!pr_b && n < 50) begin tick(1); n++; end
      if (n >= 50) chk("b_ready_timeout", 0, 1);
      tick(1);
    end
    pv_b = 1'b0;
    n = 0;
    while (done_cnt_b == 0 && n < 100) begin @(negedge clk); #1; n++; end
    tick(10);
    chk("b_done_count", done_cnt_b, 1);
    chk("b_res_count", rq_b.size(), 3);
    chk("b_patch_count", pcyc_b.size(), 3);
    eb = '{63, 72, 81};
    for (int i = 0; i < 3; i++) begin
      gb = (i < rq_b.size()) ? rq_b[i] : 10'h3ff;
      chk($sformatf("b_res%0d", i), gb, eb[i]);
      if (i < rcyc_b.size() && i < pcyc_b.size())
        chk($sformatf("b_lat%0d", i), rcyc_b[i] - pcyc_b[i], 3);
      else
        chk($sformatf("b_lat%0d_missing", i), 0, 1);
    end
    if (rcyc_b.size() == 3) chk("b_done_after_last", done_cyc_b - rcyc_b[2], 1);
    else chk("b_done_after_last_missing", 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
